// File: rtl/ads41_cal_pkg.sv
// Shared types and constants for the ads41 IDELAY tap calibration controller.
package ads41_cal_pkg;

  localparam int TAP_W = 5;
  localparam int NTAPS = 32;

  typedef enum logic [2:0] {
    CAL_IDLE,
    CAL_ZERO,
    CAL_SETTLE,
    CAL_SAMPLE,
    CAL_ANALYZE,
    CAL_PARK,
    CAL_FINISH
  } cal_state_t;

  // Each DDR lane carries two adjacent bits of the ADC word.
  function automatic int lane_count(input int nbits);
    return nbits / 2;
  endfunction

endpackage

// File: rtl/ads41_cal_window.sv
// Per-lane longest-passing-run tracker: one pass bit per cycle, reports the
// centre of the earliest longest run and whether it is wide enough.
module ads41_cal_window
  import ads41_cal_pkg::*;
#(
  parameter int MIN_WINDOW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [TAP_W-1:0] idx,
  input  logic             pass_bit,
  output logic [TAP_W-1:0] centre,
  output logic             ok
);

  logic [TAP_W:0]   run_len, best_len, cur_len;
  logic [TAP_W-1:0] run_start, best_start, cur_start;

  always_comb begin
    cur_len   = pass_bit ? run_len + 1'b1 : '0;
    cur_start = (run_len == '0) ? idx : run_start;
  end

  // Best is only replaced by a strictly longer run, so earlier runs win ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_len    <= '0;
      run_start  <= '0;
      best_len   <= '0;
      best_start <= '0;
    end else if (clear) begin
      run_len    <= '0;
      run_start  <= '0;
      best_len   <= '0;
      best_start <= '0;
    end else if (en) begin
      run_len   <= cur_len;
      run_start <= cur_start;
      if (cur_len > best_len) begin
        best_len   <= cur_len;
        best_start <= cur_start;
      end
    end
  end

  assign centre = best_start + TAP_W'(best_len >> 1);
  assign ok     = best_len >= (TAP_W+1)'(MIN_WINDOW);

endmodule

// File: rtl/ads41_idelay_cal.sv
// IDELAY tap calibration for one ads41 receiver: sweeps all lanes through
// taps 0..31 against a fixed test pattern and parks each at its window centre.
module ads41_idelay_cal
  import ads41_cal_pkg::*;
#(
  parameter int               NBITS        = 12,
  parameter int               IDELAY_VALUE = 8,
  parameter logic [NBITS-1:0] PATTERN      = 12'hA5C,
  parameter int               SETTLE       = 16,
  parameter int               NSAMPLES     = 64,
  parameter int               MIN_WINDOW   = 4,
  localparam int              NLANES       = lane_count(NBITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NBITS-1:0]        d_in,
  output logic [31:0]             idelay_val,
  output logic [15:0]             idelay_ctrl,
  output logic                    busy,
  output logic                    done,
  output logic [NLANES-1:0]       lane_ok,
  output logic [TAP_W*NLANES-1:0] lane_tap
);

  localparam logic [NLANES-1:0] ALL_LANES = '1;

  cal_state_t       state, next_state;
  logic [15:0]      cnt;
  logic             ph;
  logic             analyzed;
  logic             inc;
  logic             win_clear;
  logic             sample_last, tap_top;
  logic [NLANES-1:0] strobe, lane_err, fail_acc, zero_mask, park_mask, win_ok;
  logic [TAP_W-1:0] tap    [NLANES];
  logic [TAP_W-1:0] target [NLANES];
  logic [TAP_W-1:0] centre [NLANES];
  logic [NTAPS-1:0] pass   [NLANES];

  assign sample_last = cnt == 16'(NSAMPLES - 1);
  assign tap_top     = tap[0] == TAP_W'(NTAPS - 1);
  assign win_clear   = (state == CAL_IDLE) && start;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    assign lane_err[i]  = d_in[2*i +: 2] != PATTERN[2*i +: 2];
    assign zero_mask[i] = tap[i] != '0;
    assign target[i]    = win_ok[i] ? centre[i] : TAP_W'(IDELAY_VALUE);
    assign park_mask[i] = tap[i] > target[i];

    ads41_cal_window #(.MIN_WINDOW(MIN_WINDOW)) u_win (
      .clk      (clk),
      .rst      (rst),
      .clear    (win_clear),
      .en       (state == CAL_ANALYZE),
      .idx      (cnt[TAP_W-1:0]),
      .pass_bit (pass[i][cnt[TAP_W-1:0]]),
      .centre   (centre[i]),
      .ok       (win_ok[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CAL_IDLE;
    else     state <= next_state;
  end

  // Steps strobe while ph is low and hold direction for the following cycle.
  // ZERO walks down until every lane reads 0, so a repeat start is safe too.
  always_comb begin
    next_state = state;
    strobe     = '0;
    inc        = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      CAL_IDLE: begin
        busy = 1'b0;
        if (start) next_state = CAL_ZERO;
      end
      CAL_ZERO: begin
        if (!ph) begin
          if (zero_mask == '0) next_state = CAL_SETTLE;
          else                 strobe     = zero_mask;
        end
      end
      CAL_SETTLE: begin
        if (cnt == 16'(SETTLE - 1)) next_state = CAL_SAMPLE;
      end
      CAL_SAMPLE: begin
        if (sample_last && tap_top) begin
          next_state = CAL_ANALYZE;
        end else if (cnt == 16'(NSAMPLES)) begin
          strobe = ALL_LANES;
          inc    = 1'b1;
        end else if (cnt == 16'(NSAMPLES + 1)) begin
          inc        = 1'b1;
          next_state = CAL_SETTLE;
        end
      end
      CAL_ANALYZE: begin
        if (cnt == 16'(NTAPS - 1)) next_state = CAL_PARK;
      end
      CAL_PARK: begin
        if (!ph) begin
          if (park_mask == '0) next_state = CAL_FINISH;
          else                 strobe     = park_mask;
        end
      end
      CAL_FINISH: begin
        busy       = 1'b0;
        done       = 1'b1;
        next_state = CAL_IDLE;
      end
      default: next_state = CAL_IDLE;
    endcase
  end

  assign idelay_ctrl = 16'(strobe);
  assign idelay_val  = inc ? 32'(ALL_LANES) : 32'd0;
  assign lane_ok     = analyzed ? win_ok : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      ph       <= 1'b0;
      analyzed <= 1'b0;
      fail_acc <= '0;
      lane_tap <= '0;
      for (int i = 0; i < NLANES; i++) begin
        tap[i]  <= TAP_W'(IDELAY_VALUE);
        pass[i] <= '0;
      end
    end else begin
      ph  <= |strobe;
      cnt <= (next_state != state) ? '0 : cnt + 1'b1;
      for (int i = 0; i < NLANES; i++) begin
        if (strobe[i]) tap[i] <= inc ? tap[i] + 1'b1 : tap[i] - 1'b1;
      end
      case (state)
        CAL_IDLE: begin
          if (start) begin
            analyzed <= 1'b0;
            fail_acc <= '0;
            for (int i = 0; i < NLANES; i++) pass[i] <= '0;
          end
        end
        CAL_SAMPLE: begin
          if (cnt < 16'(NSAMPLES)) begin
            if (sample_last) begin
              for (int i = 0; i < NLANES; i++)
                pass[i][tap[0]] <= !(fail_acc[i] | lane_err[i]);
              fail_acc <= '0;
            end else begin
              fail_acc <= fail_acc | lane_err;
            end
          end
        end
        CAL_ANALYZE: begin
          if (next_state == CAL_PARK) analyzed <= 1'b1;
        end
        CAL_PARK: begin
          if (next_state == CAL_FINISH)
            for (int i = 0; i < NLANES; i++) lane_tap[TAP_W*i +: TAP_W] <= target[i];
        end
        default: ;
      endcase
    end
  end

  // A step that would wrap the 5-bit tap model means the sequencing is broken.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NLANES; i++) begin
        if (strobe[i]) assert (inc ? tap[i] != TAP_W'(NTAPS - 1) : tap[i] != '0);
      end
    end
  end

endmodule

// File: tb/tb_ads41_idelay_cal.sv
// Self-checking bench: behavioural IDELAY/ADC lane model with per-lane pass
// windows, and a run-based reference for the expected park taps.
module tb_ads41_idelay_cal;

  localparam int          NL   = 6;
  localparam int          IDV  = 8;
  localparam int          MINW = 4;
  localparam logic [11:0] PAT  = 12'hA5C;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] d_in;
  logic [31:0] idelay_val;
  logic [15:0] idelay_ctrl;
  logic        busy, done;
  logic [5:0]  lane_ok;
  logic [29:0] lane_tap;

  ads41_idelay_cal #(
    .NBITS(12), .IDELAY_VALUE(IDV), .PATTERN(PAT),
    .SETTLE(16), .NSAMPLES(64), .MIN_WINDOW(MINW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .d_in        (d_in),
    .idelay_val  (idelay_val),
    .idelay_ctrl (idelay_ctrl),
    .busy        (busy),
    .done        (done),
    .lane_ok     (lane_ok),
    .lane_tap    (lane_tap)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] win [NL];
  int          rx_tap [NL];
  int          lane_strobes [NL];
  int          events, done_cnt, viol;
  logic [15:0] prev_ctrl;
  logic [31:0] prev_val;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Receiver model: tap moves on each CE strobe, data is clean inside the window.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) rx_tap[i] = IDV;
      prev_ctrl = '0;
      prev_val  = '0;
    end else begin
      if (idelay_ctrl[15:NL] != '0 || idelay_val[31:NL] != '0) viol++;
      if (prev_ctrl != '0 && idelay_ctrl != '0) viol++;
      if (prev_ctrl != '0 && idelay_val != prev_val) viol++;
      if (idelay_ctrl != '0) events++;
      if (done) done_cnt++;
      for (int i = 0; i < NL; i++) begin
        if (idelay_ctrl[i]) begin
          lane_strobes[i]++;
          if (idelay_val[i]) begin
            if (rx_tap[i] == 31) viol++; else rx_tap[i]++;
          end else begin
            if (rx_tap[i] == 0) viol++; else rx_tap[i]--;
          end
        end
      end
      prev_ctrl = idelay_ctrl;
      prev_val  = idelay_val;
    end
    for (int i = 0; i < NL; i++)
      d_in[2*i +: 2] = win[i][rx_tap[i]] ? PAT[2*i +: 2] : PAT[2*i +: 2] ^ 2'($urandom_range(1, 3));
  end

  function automatic logic [31:0] span(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  // Enumerate maximal runs; keep the first of the longest.
  function automatic void ref_lane(input logic [31:0] m, output logic ok, output int tgt);
    int best_s = 0, best_l = 0, s = 0, l = 0;
    for (int k = 0; k <= 32; k++) begin
      if (k < 32 && m[k]) begin
        if (l == 0) s = k;
        l++;
      end else begin
        if (l > best_l) begin
          best_l = l;
          best_s = s;
        end
        l = 0;
      end
    end
    ok  = best_l >= MINW;
    tgt = ok ? best_s + best_l / 2 : IDV;
  endfunction

  task automatic doReset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit hold_start);
    int n = 0;
    @(negedge clk);
    events = 0;
    done_cnt = 0;
    viol = 0;
    for (int i = 0; i < NL; i++) lane_strobes[i] = 0;
    start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    checkOutput("busy_rise", busy, 1);
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checkOutput("done_seen", done, 1);
    repeat (3) @(negedge clk);
    checkOutput("busy_end", busy, 0);
  endtask

  task automatic checkResult(input string nm);
    logic       ok;
    int         t;
    int         maxdn = 0;
    logic [5:0] exp_ok;
    for (int i = 0; i < NL; i++) begin
      ref_lane(win[i], ok, t);
      exp_ok[i] = ok;
      if (31 - t > maxdn) maxdn = 31 - t;
      checkOutput($sformatf("%s_tap%0d", nm, i), lane_tap[5*i +: 5], t);
      checkOutput($sformatf("%s_strb%0d", nm, i), lane_strobes[i], IDV + 31 + (31 - t));
      checkOutput($sformatf("%s_rx%0d", nm, i), rx_tap[i], t);
    end
    checkOutput({nm, "_ok"}, lane_ok, exp_ok);
    checkOutput({nm, "_events"}, events, IDV + 31 + maxdn);
    checkOutput({nm, "_done"}, done_cnt, 1);
    checkOutput({nm, "_proto"}, viol, 0);
  endtask

  task automatic runCase(input string nm);
    doReset();
    applyStimulus(1'b0);
    checkResult(nm);
  endtask

  initial begin
    int kind, lo, hi;
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < NL; i++) win[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ok", lane_ok, 0);
    checkOutput("rst_tap", lane_tap, 0);
    checkOutput("rst_ctrl", idelay_ctrl, 0);
    checkOutput("rst_val", idelay_val, 0);

    for (int i = 0; i < NL; i++) win[i] = span(10, 20);
    runCase("all10_20");

    for (int i = 0; i < NL; i++) win[i] = span(5, 9);
    win[2] = span(0, 3) | span(25, 31);
    runCase("lane2_split");

    for (int i = 0; i < NL; i++) win[i] = span(5, 9);
    win[4] = '0;
    runCase("lane4_dead");

    for (int i = 0; i < NL; i++) win[i] = span(12, 18);
    win[0] = span(2, 6) | span(20, 24);
    win[1] = span(0, 31);
    win[3] = span(31, 31);
    win[5] = span(28, 31);
    runCase("tie_edges");

    // Reset in the middle of the sweep, then a rerun with start held high.
    for (int i = 0; i < NL; i++) win[i] = span(10, 20);
    doReset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    checkOutput("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_ok", lane_ok, 0);
    checkOutput("mid_rst_tap", lane_tap, 0);
    checkOutput("mid_rst_ctrl", idelay_ctrl, 0);
    checkOutput("mid_rst_val", idelay_val, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1);
    checkResult("rerun_held");

    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NL; i++) begin
        kind = int'($urandom_range(0, 3));
        win[i] = '0;
        if (kind != 0) begin
          lo = int'($urandom_range(0, 31));
          hi = int'($urandom_range(lo, (lo + 12 > 31) ? 31 : lo + 12));
          win[i] = span(lo, hi);
          if (kind == 3) begin
            lo = int'($urandom_range(0, 31));
            hi = int'($urandom_range(lo, 31));
            win[i] = win[i] | span(lo, hi);
          end
        end
      end
      runCase($sformatf("rand%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ads41_idelay_cal.md
Name: ads41_idelay_cal

Overview:
- Automatic IDELAY tap calibration controller for one ads41 ADC receiver (6 DDR lanes).
- The ADC is held in a fixed test-pattern mode. The controller sweeps every lane's IDELAY through taps 0..31, scores each tap against the expected word, and parks each lane at the centre of its longest passing window.
- Drives the receiver's idelay_val/idelay_ctrl inc/strobe interface.
- Reads the receiver's FIFO output word in the same user clock domain; idelay_clk is tied to clk.

Parameters:
- NBITS, 12, ADC word width; NLANES = NBITS/2 DDR lanes; lane i carries word bits 2i and 2i+1.
- IDELAY_VALUE, 8, tap the receiver loads on reset; the controller's starting tap model.
- PATTERN, 12'hA5C, expected ADC test-pattern word.
- SETTLE, 16, cycles waited after each tap change before sampling; must exceed FIFO + IDDR latency.
- NSAMPLES, 64, consecutive compared words per tap.
- MIN_WINDOW, 4, minimum passing run length for a lane to be declared good.

Ports:
- clk  in  1  user clock; also the receiver's idelay_clk.
- rst  in  1  asynchronous active-high reset; must be the same net as the receiver rst so the IDELAY LD and the tap model reset together.
- start  in  1  one-cycle pulse that begins calibration; ignored unless IDLE.
- d_in  in  NBITS  receiver data word (d_out).
- idelay_val  out  32  per-lane INC direction; bit i = 1 increments, 0 decrements; bits >= NLANES are 0.
- idelay_ctrl  out  16  per-lane CE strobe; the receiver acts on the rising edge; bits >= NLANES are 0.
- busy  out  1  high from start acceptance until done.
- done  out  1  single-cycle pulse at completion.
- lane_ok  out  NLANES  lane i had best window length >= MIN_WINDOW; sticky until next start.
- lane_tap  out  5*NLANES  final tap per lane, packed, lane 0 in bits [4:0].

Behaviour:
- Reset values: all outputs 0; state IDLE; tap model = IDELAY_VALUE on all lanes; scoreboards cleared.
- Step primitive, used by every state that moves taps:
  - cycle 0: idelay_val holds direction; idelay_ctrl = lane mask.
  - cycle 1: idelay_ctrl = 0, direction held.
  - The tap model updates at cycle 1.
  - Minimum spacing is 2 cycles per step; no back-to-back strobes.
- States:
  - IDLE: on start, busy = 1, clear lane_ok and scoreboards, go to ZERO.
  - ZERO: issue IDELAY_VALUE decrement steps on all lanes, so all taps = 0, then go to SETTLE.
  - SETTLE: count SETTLE cycles, then go to SAMPLE.
  - SAMPLE: for NSAMPLES cycles, lane i fails at the current tap if d_in[2i+1:2i] != PATTERN[2i+1:2i] on any cycle. At the end, write pass[i][tap]. If tap < 31, issue one increment step on all lanes and go to SETTLE; else go to ANALYZE.
  - ANALYZE: 32 cycles, index k = 0..31, all lanes in parallel.
    - Track run_start, run_len, best_start and best_len per lane.
    - A run ends on a fail bit or at k = 31.
    - Replace best only if run_len > best_len, so the earliest longest run wins ties.
    - Runs do not wrap from 31 to 0.
    - centre = best_start + best_len/2 (floor).
    - If best_len < MIN_WINDOW: lane_ok[i] = 0 and target = IDELAY_VALUE; else lane_ok[i] = 1 and target = centre.
  - PARK: all taps are at 31. Issue decrement steps with mask = lanes whose tap model > target, until the mask is empty.
  - FINISH: lane_tap = targets; done = 1 for one cycle; busy = 0; go to IDLE.
- Boundaries:
  - Never increment past 31 or decrement below 0.
  - The tap model width is 5 bits; overflow is a bug, and assertions must fire on it.
  - All-pass lane: centre = 16.
  - All-fail lane: lane_ok = 0, target = IDELAY_VALUE.
  - If a lane's target = 31, its PARK mask bit is never set.
- start while busy: ignored.
- rst mid-operation: immediate return to IDLE with all outputs 0; tap model = IDELAY_VALUE, which matches the receiver LD.
- Total strobes per run: IDELAY_VALUE + 31 + max over lanes of (31 - target).

Decomposition:
- Shared package ads41_cal_pkg:
  - state enum (IDLE, ZERO, SETTLE, SAMPLE, ANALYZE, PARK, FINISH)
  - TAP_W = 5, NTAPS = 32
  - lane-count function of NBITS
- One sub-module, ads41_cal_window: per-lane run/best tracker, 1 bit in per cycle; outputs centre and ok. Instantiated NLANES times.

Test Plan:
- Test environment: behavioural IDELAY tap model plus a data model in which lane i returns PATTERN when the tap is inside [lo_i, hi_i], else random.
- All lanes pass 10..20: start -> 8 decrement strobes, 31 increment strobes, 16 decrement strobes; lane_tap all 15; lane_ok = 6'h3F; done pulses once.
- Lane 2 passes 0..3 and 25..31, others pass 5..9: lane 2 target 28, others 7; lane_ok = 6'h3F.
- Lane 4 never passes: lane_ok[4] = 0; lane 4 tap = 8; its PARK strobes = 23; other lanes unaffected.
- Tie, lane 0 passes 2..6 and 20..24: first window wins; lane 0 tap = 4.
- Strobe protocol checks:
  - every idelay_ctrl high pulse is exactly 1 cycle, followed by at least 1 low cycle;
  - idelay_val is stable during each pulse;
  - bits [15:NLANES] of idelay_ctrl and bits [31:NLANES] of idelay_val are always 0.
- Reset mid-SAMPLE, then start held high while busy: outputs 0 immediately; re-run is identical to a clean run; start while busy has no effect.
